// File: rtl/mux_pkg.sv
// Shared constants and select-range helper for the 10:1 lane selector.
// Used by mux_10x1; see its header for the MUX10_HOLD_INVALID_EN build option.
package mux_pkg;

   localparam int NUM_LANES = 10;
   localparam int SEL_W     = 4;
   localparam int MAX_SEL   = 9;

   // Stage-2 group chosen by the upper select bits.
   typedef enum logic [1:0] {
      GRP_LOW  = 2'd0,
      GRP_MID  = 2'd1,
      GRP_HIGH = 2'd2,
      GRP_NONE = 2'd3
   } sel_grp_e;

   function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel);
      return (sel > SEL_W'(MAX_SEL));
   endfunction

endpackage

// File: rtl/mux_4x1.sv
// Purely combinational 4:1 multiplexer, the building block of both stages of mux_10x1.
module mux_4x1 #(
   parameter int DATA_W = 1
) (
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   input  logic [1:0]        sel,
   output logic [DATA_W-1:0] y
);

   // select one of the four inputs
   always_comb begin
      y = {DATA_W{1'b0}};
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         2'd3:    y = d3;
         default: y = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/mux_10x1.sv
// 10:1 lane selector built from two levels of 4:1 muxes, registered output and sel_err flag.
// Build option MUX10_HOLD_INVALID_EN: an out-of-range select holds y instead of loading zero.
module mux_10x1
   import mux_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_LANES*DATA_W-1:0]   i,
   input  logic [SEL_W-1:0]              s,
   output logic [DATA_W-1:0]             y,
   output logic                          sel_err
);

   localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

   logic [DATA_W-1:0] lane_s [NUM_LANES];
   logic [DATA_W-1:0] m0_s;
   logic [DATA_W-1:0] m1_s;
   logic [DATA_W-1:0] m2_s;
   logic [DATA_W-1:0] sel_val_s;
   logic [DATA_W-1:0] next_y_s;
   logic              err_s;
   sel_grp_e          grp_s;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_s[k] = i[k*DATA_W +: DATA_W];
   end

   assign grp_s = sel_grp_e'(s[3:2]);
   assign err_s = sel_out_of_range(s);

   mux_4x1 #(.DATA_W(DATA_W)) u_m0 (
      .d0 (lane_s[0]), .d1 (lane_s[1]), .d2 (lane_s[2]), .d3 (lane_s[3]),
      .sel(s[1:0]), .y(m0_s)
   );

   mux_4x1 #(.DATA_W(DATA_W)) u_m1 (
      .d0 (lane_s[4]), .d1 (lane_s[5]), .d2 (lane_s[6]), .d3 (lane_s[7]),
      .sel(s[1:0]), .y(m1_s)
   );

   // lanes 10 and 11 do not exist, so the upper two inputs are tied to zero
   mux_4x1 #(.DATA_W(DATA_W)) u_m2 (
      .d0 (lane_s[8]), .d1 (lane_s[9]), .d2 (ZERO), .d3 (ZERO),
      .sel(s[1:0]), .y(m2_s)
   );

   mux_4x1 #(.DATA_W(DATA_W)) u_stage2 (
      .d0 (m0_s), .d1 (m1_s), .d2 (m2_s), .d3 (ZERO),
      .sel(grp_s), .y(sel_val_s)
   );

   // next value for y; the mux tree already yields zero for s = 10..15
   always_comb begin
      next_y_s = sel_val_s;
`ifdef MUX10_HOLD_INVALID_EN
      if (err_s) begin
         next_y_s = y;
      end else begin
         next_y_s = sel_val_s;
      end
`else
      next_y_s = sel_val_s;
`endif
   end

   // output register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y       <= ZERO;
         sel_err <= 1'b0;
      end else begin
         y       <= next_y_s;
         sel_err <= err_s;
      end
   end

endmodule

// File: tb/tb_mux_10x1.sv
// Self-checking bench for mux_10x1: a 1-bit and an 8-bit instance against a lane-array model.
module tb_mux_10x1;

   logic        clk;
   logic        rst;
   logic [9:0]  i1;
   logic [3:0]  s1;
   logic [0:0]  y1;
   logic        e1;
   logic [79:0] i8;
   logic [3:0]  s8;
   logic [7:0]  y8;
   logic        e8;

   int checks;
   int errors;

   logic [7:0] exp_y1;
   logic       exp_e1;
   logic [7:0] exp_y8;
   logic       exp_e8;

   logic [9:0]  pat1;
   logic [79:0] wide8;

   mux_10x1 #(.DATA_W(1)) dut1 (
      .clk(clk), .rst(rst), .i(i1), .s(s1), .y(y1), .sel_err(e1)
   );

   mux_10x1 #(.DATA_W(8)) dut8 (
      .clk(clk), .rst(rst), .i(i8), .s(s8), .y(y8), .sel_err(e8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: split the bus into lanes, then pick lane sel; bad selects give zero or hold.
   function automatic logic [7:0] model(input logic [79:0] bus, input int w,
                                        input int sel, input logic [7:0] prev);
      logic [7:0] lanes [10];
      logic [79:0] mask;
      mask = (80'd1 << w) - 80'd1;
      for (int k = 0; k < 10; k++) lanes[k] = 8'((bus >> (k * w)) & mask);
      if (sel < 10) return lanes[sel];
`ifdef MUX10_HOLD_INVALID_EN
      return prev;
`else
      return 8'd0;
`endif
   endfunction

   task automatic step(input logic [9:0] ni1, input logic [3:0] ns1,
                       input logic [79:0] ni8, input logic [3:0] ns8);
      @(negedge clk);
      i1 = ni1; s1 = ns1; i8 = ni8; s8 = ns8;
      @(posedge clk);
      exp_y1 = model({70'd0, ni1}, 1, int'(ns1), exp_y1);
      exp_e1 = (ns1 > 4'd9);
      exp_y8 = model(ni8, 8, int'(ns8), exp_y8);
      exp_e8 = (ns8 > 4'd9);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i1 = 10'd0; s1 = 4'd0; i8 = 80'd0; s8 = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b0 || e1 !== 1'b0 || y8 !== 8'd0 || e8 !== 1'b0) begin
         errors++; $display("FAIL reset_state: y1=%0d e1=%0d y8=%0h e8=%0d required 0", y1, e1, y8, e8);
      end
      @(negedge clk); rst = 1'b0;
      exp_y1 = 8'd0; exp_e1 = 1'b0; exp_y8 = 8'd0; exp_e8 = 1'b0;
      step(10'b0000000001, 4'd0, 80'd0, 4'd0);
      checks++;
      if (y1 !== 1'b1) begin
         errors++; $display("FAIL reset_preload: y1=%0d required 1", y1);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (y1 !== 1'b0 || e1 !== 1'b0) begin
         errors++; $display("FAIL reset_async: y1=%0d e1=%0d required 0 0", y1, e1);
      end
      s1 = 4'd12;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b0 || e1 !== 1'b0) begin
         errors++; $display("FAIL reset_hold: y1=%0d e1=%0d required 0 0", y1, e1);
      end
      @(negedge clk); rst = 1'b0;
      exp_y1 = 8'd0; exp_e1 = 1'b0; exp_y8 = 8'd0; exp_e8 = 1'b0;
   endtask

   task automatic test_in_range();
      logic [9:0] want;
      want = 10'b1010101011;
      for (int k = 0; k < 10; k++) begin
         step(pat1, 4'(k), wide8, 4'(k));
         checks++;
         if (y1 !== want[k] || e1 !== 1'b0) begin
            errors++; $display("FAIL in_range s=%0d: y1=%0d e1=%0d required %0d 0", k, y1, e1, want[k]);
         end
         checks++;
         if (y8 !== 8'h10 + 8'(k) || e8 !== 1'b0) begin
            errors++; $display("FAIL in_range_wide s=%0d: y8=%0h e8=%0d required %0h 0", k, y8, e8, 8'h10 + 8'(k));
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [0:0] want1;
      logic [7:0] want8;
`ifdef MUX10_HOLD_INVALID_EN
      want1 = 1'b1; want8 = 8'h19;
`else
      want1 = 1'b0; want8 = 8'h00;
`endif
      for (int k = 10; k < 16; k++) begin
         step(pat1, 4'(k), wide8, 4'(k));
         checks++;
         if (y1 !== want1 || e1 !== 1'b1) begin
            errors++; $display("FAIL out_of_range s=%0d: y1=%0d e1=%0d required %0d 1", k, y1, e1, want1);
         end
         checks++;
         if (y8 !== want8 || e8 !== 1'b1) begin
            errors++; $display("FAIL out_of_range_wide s=%0d: y8=%0h e8=%0d required %0h 1", k, y8, e8, want8);
         end
      end
   endtask

   task automatic test_latency();
      step(pat1, 4'd2, wide8, 4'd2);
      checks++;
      if (y1 !== 1'b0) begin
         errors++; $display("FAIL latency_s2: y1=%0d required 0", y1);
      end
      #1 s1 = 4'd3;
      #2;
      checks++;
      if (y1 !== 1'b0) begin
         errors++; $display("FAIL latency_comb: y1=%0d required 0 before edge", y1);
      end
      step(pat1, 4'd3, wide8, 4'd3);
      checks++;
      if (y1 !== 1'b1) begin
         errors++; $display("FAIL latency_s3: y1=%0d required 1", y1);
      end
   endtask

   task automatic test_wide();
      logic [7:0] want12;
`ifdef MUX10_HOLD_INVALID_EN
      want12 = 8'h19;
`else
      want12 = 8'h00;
`endif
      step(pat1, 4'd0, wide8, 4'd7);
      checks++;
      if (y8 !== 8'h17) begin
         errors++; $display("FAIL wide_s7: y8=%0h required 17", y8);
      end
      step(pat1, 4'd0, wide8, 4'd9);
      checks++;
      if (y8 !== 8'h19) begin
         errors++; $display("FAIL wide_s9: y8=%0h required 19", y8);
      end
      step(pat1, 4'd0, wide8, 4'd12);
      checks++;
      if (y8 !== want12 || e8 !== 1'b1) begin
         errors++; $display("FAIL wide_s12: y8=%0h e8=%0d required %0h 1", y8, e8, want12);
      end
   endtask

   task automatic test_simultaneous();
      step(10'h000, 4'd0, wide8, 4'd0);
      step(10'h200, 4'd9, wide8, 4'd0);
      checks++;
      if (y1 !== 1'b1 || e1 !== 1'b0) begin
         errors++; $display("FAIL simultaneous: y1=%0d e1=%0d required 1 0", y1, e1);
      end
   endtask

   task automatic test_random();
      logic [79:0] r8;
      for (int n = 0; n < 300; n++) begin
         r8 = {$urandom, $urandom, $urandom};
         step(10'($urandom), 4'($urandom_range(0, 15)), r8, 4'($urandom_range(0, 15)));
         checks++;
         if (y1 !== exp_y1[0] || e1 !== exp_e1) begin
            errors++; $display("FAIL random_1 n=%0d s=%0d: y1=%0d e1=%0d required %0d %0d", n, s1, y1, e1, exp_y1[0], exp_e1);
         end
         checks++;
         if (y8 !== exp_y8 || e8 !== exp_e8) begin
            errors++; $display("FAIL random_8 n=%0d s=%0d: y8=%0h e8=%0d required %0h %0d", n, s8, y8, e8, exp_y8, exp_e8);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      pat1 = 10'b1010101011;
      for (int k = 0; k < 10; k++) wide8[k*8 +: 8] = 8'h10 + 8'(k);
      test_reset();
      test_in_range();
      test_out_of_range();
      test_latency();
      test_wide();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
